// File: rtl/boton_antirrebote.sv
//==============================================================================
// Module      : boton_antirrebote
// Description : Pushbutton debouncer. The raw button is passed through a
//               2-FF synchroniser, then a 4-state FSM with a stability
//               counter accepts a new level only after it has been stable
//               for CICLOS_ESTABLE cycles. Each validated press produces a
//               single-cycle step pulse used as a counter clock enable.
//
//               Optional feature macro: REPETICION_EN
//                 defined   -> auto-repeat pulses while the button is held
//                              (first after RETARDO_REP, then every
//                              PERIODO_REP cycles)
//                 undefined -> exactly one pulse per press; no repeat logic
//
// Ports       : iClk     in   system clock, rising edge
//               iRst_n   in   asynchronous active-low reset
//               iBoton   in   raw button, asynchronous, may bounce
//               oNivel   out  debounced level, 1 = pressed (registered)
//               oPulso   out  one-cycle step pulse per press (registered)
//               oEstado  out  current FSM state for debug/LEDs
//
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module boton_antirrebote #(
    parameter int CICLOS_ESTABLE = 50000,
    parameter int ANCHO_CNT      = 16,
    parameter bit ACTIVO_ALTO    = 1'b1,
    parameter int RETARDO_REP    = 25000000,
    parameter int PERIODO_REP    = 5000000
) (
    input  logic       iClk,
    input  logic       iRst_n,
    input  logic       iBoton,
    output logic       oNivel,
    output logic       oPulso,
    output logic [1:0] oEstado
);

    typedef enum logic [1:0] {
        SUELTO         = 2'd0,
        VALIDA_PRESION = 2'd1,
        PRESIONADO     = 2'd2,
        VALIDA_SUELTA  = 2'd3
    } estado_t;

    localparam logic [ANCHO_CNT-1:0] c_limite_estable = ANCHO_CNT'(CICLOS_ESTABLE - 1);
    // Raw level of a released button; the synchroniser resets to it so that
    // reset never looks like a press, whatever the polarity.
    localparam logic                 c_reposo         = ACTIVO_ALTO ? 1'b0 : 1'b1;

`ifdef REPETICION_EN
    localparam logic [ANCHO_CNT-1:0] c_limite_retardo = ANCHO_CNT'(RETARDO_REP - 1);
    localparam logic [ANCHO_CNT-1:0] c_limite_periodo = ANCHO_CNT'(PERIODO_REP - 1);
`endif

    // Elaboration-time parameter sanity checks
    generate
        if (CICLOS_ESTABLE < 2 ||
            (ANCHO_CNT < 31 && (1 << ANCHO_CNT) <= CICLOS_ESTABLE)) begin : g_err_estable
            $error("boton_antirrebote: CICLOS_ESTABLE must be >= 2 and fit in ANCHO_CNT bits");
        end
        if (RETARDO_REP < 1 || PERIODO_REP < 1) begin : g_err_rep
            $error("boton_antirrebote: RETARDO_REP and PERIODO_REP must be >= 1");
        end
`ifdef REPETICION_EN
        if (ANCHO_CNT < 31 &&
            ((1 << ANCHO_CNT) <= RETARDO_REP || (1 << ANCHO_CNT) <= PERIODO_REP)) begin : g_err_ancho_rep
            $error("boton_antirrebote: repeat parameters do not fit in ANCHO_CNT bits");
        end
`endif
    endgenerate

    logic                 sync1_q;
    logic                 sync2_q;
    logic                 s;
    estado_t              estado_q;
    estado_t              estado_d;
    logic [ANCHO_CNT-1:0] cnt_q;
    logic [ANCHO_CNT-1:0] cnt_d;
    logic                 nivel_q;
    logic                 nivel_d;
    logic                 pulso_q;
    logic                 pulso_d;
`ifdef REPETICION_EN
    // Set once the first (long) repeat delay has elapsed in the current hold
    logic                 rep_q;
    logic                 rep_d;
`endif

    // Polarity-corrected synchronised level: 1 = pressed
    assign s = sync2_q ^ c_reposo;

    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        pulso_d  = 1'b0;
`ifdef REPETICION_EN
        rep_d    = rep_q;
`endif
        case (estado_q)
            SUELTO: begin
                if (s) begin
                    estado_d = VALIDA_PRESION;
                    cnt_d    = '0;
                end
            end
            VALIDA_PRESION: begin
                if (!s) begin
                    // Glitch: drop back without a pulse
                    estado_d = SUELTO;
                    cnt_d    = '0;
                end else if (cnt_q == c_limite_estable) begin
                    estado_d = PRESIONADO;
                    cnt_d    = '0;
                    pulso_d  = 1'b1;
`ifdef REPETICION_EN
                    rep_d    = 1'b0;
`endif
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            PRESIONADO: begin
                if (!s) begin
                    estado_d = VALIDA_SUELTA;
                    cnt_d    = '0;
`ifdef REPETICION_EN
                end else if (cnt_q == (rep_q ? c_limite_periodo : c_limite_retardo)) begin
                    pulso_d = 1'b1;
                    cnt_d   = '0;
                    rep_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
`endif
                end
            end
            VALIDA_SUELTA: begin
                if (s) begin
                    // Release bounce: back to pressed, no new pulse
                    estado_d = PRESIONADO;
                    cnt_d    = '0;
`ifdef REPETICION_EN
                    rep_d    = 1'b0;
`endif
                end else if (cnt_q == c_limite_estable) begin
                    estado_d = SUELTO;
                    cnt_d    = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                estado_d = SUELTO;
                cnt_d    = '0;
            end
        endcase

        // Outputs are registered from the next state so they line up with it
        nivel_d = (estado_d == PRESIONADO) || (estado_d == VALIDA_SUELTA);
    end

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync1_q  <= c_reposo;
            sync2_q  <= c_reposo;
            estado_q <= SUELTO;
            cnt_q    <= '0;
            nivel_q  <= 1'b0;
            pulso_q  <= 1'b0;
`ifdef REPETICION_EN
            rep_q    <= 1'b0;
`endif
        end else begin
            sync1_q  <= iBoton;
            sync2_q  <= sync1_q;
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            nivel_q  <= nivel_d;
            pulso_q  <= pulso_d;
`ifdef REPETICION_EN
            rep_q    <= rep_d;
`endif
        end
    end

    assign oNivel  = nivel_q;
    assign oPulso  = pulso_q;
    assign oEstado = estado_q;

endmodule

`default_nettype wire
